// File: rtl/ds1302_slave.sv
// ds1302_slave: DS1302-style 3-wire serial responder with a 2x32-byte
// register file that is also reachable through a local parallel port.
module ds1302_slave (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce_in,
  input  logic       sclk_in,
  input  logic       io_in,
  output logic       io_out,
  output logic       io_oe,
  input  logic [5:0] loc_addr,
  input  logic [7:0] loc_wdata,
  input  logic       loc_we,
  output logic [7:0] loc_rdata,
  output logic       wr_strobe,
  output logic       rd_strobe,
  output logic [5:0] evt_addr,
  output logic       loc_collision
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WDATA,
    S_RDATA,
    S_DONE
  } state_t;

  state_t     state, state_n;
  logic       ce_s1, ce_s2, ce_q;
  logic       sclk_s1, sclk_s2, sclk_q;
  logic       io_s1, io_s2, io_q;
  logic       ce_rise, ce_fall;
  logic       sclk_rise, sclk_fall;
  logic [3:0] cnt, cnt_n;
  logic [6:0] shreg, shreg_n;
  logic [7:0] shifted;
  logic [5:0] addr, addr_n;
  logic [7:0] rbuf, rbuf_n;
  logic       io_out_n, io_oe_n;
  logic       wr_evt, rd_evt;
  logic       wp, ser_ok, loc_ok, clash;
  logic [7:0] mem [64];

  // CE resets high so a CE held across reset never looks like a new rise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ce_s1   <= 1'b1;
      ce_s2   <= 1'b1;
      ce_q    <= 1'b1;
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_q  <= 1'b0;
      io_s1   <= 1'b0;
      io_s2   <= 1'b0;
      io_q    <= 1'b0;
    end else begin
      ce_s1   <= ce_in;
      ce_s2   <= ce_s1;
      ce_q    <= ce_s2;
      sclk_s1 <= sclk_in;
      sclk_s2 <= sclk_s1;
      sclk_q  <= sclk_s2;
      io_s1   <= io_in;
      io_s2   <= io_s1;
      io_q    <= io_s2;
    end
  end

  assign ce_rise   = ce_s2 & ~ce_q;
  assign ce_fall   = ~ce_s2 & ce_q;
  assign sclk_rise = sclk_s2 & ~sclk_q;
  assign sclk_fall = ~sclk_s2 & sclk_q;
  assign shifted   = {io_q, shreg};

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    shreg_n  = shreg;
    addr_n   = addr;
    rbuf_n   = rbuf;
    io_out_n = io_out;
    io_oe_n  = io_oe;
    wr_evt   = 1'b0;
    rd_evt   = 1'b0;
    if (ce_fall) begin
      state_n  = S_IDLE;
      io_oe_n  = 1'b0;
      io_out_n = 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (ce_rise) begin
            state_n = S_CMD;
            cnt_n   = 4'd0;
            shreg_n = 7'd0;
          end
        end
        S_CMD: begin
          if (sclk_rise) begin
            shreg_n = shifted[7:1];
            cnt_n   = cnt + 4'd1;
            if (cnt == 4'd7) begin
              cnt_n  = 4'd0;
              addr_n = shifted[6:1];
              if (!shifted[7]) begin
                state_n = S_DONE;
              end else if (shifted[0]) begin
                state_n = S_RDATA;
                rd_evt  = 1'b1;
                rbuf_n  = mem[shifted[6:1]];
              end else begin
                state_n = S_WDATA;
              end
            end
          end
        end
        S_WDATA: begin
          if (sclk_rise) begin
            shreg_n = shifted[7:1];
            cnt_n   = cnt + 4'd1;
            if (cnt == 4'd7) begin
              wr_evt  = 1'b1;
              state_n = S_DONE;
            end
          end
        end
        S_RDATA: begin
          if (sclk_fall) begin
            if (cnt == 4'd8) begin
              io_oe_n  = 1'b0;
              io_out_n = 1'b0;
              state_n  = S_DONE;
            end else begin
              io_oe_n  = 1'b1;
              io_out_n = rbuf[cnt[2:0]];
              cnt_n    = cnt + 4'd1;
            end
          end
        end
        S_DONE: begin
          state_n = S_DONE;
        end
        default: begin
          state_n = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      shreg <= 7'd0;
      addr  <= 6'd0;
      rbuf  <= 8'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      shreg <= shreg_n;
      addr  <= addr_n;
      rbuf  <= rbuf_n;
    end
  end

  // WP only lets clock index 7 through; serial commit beats a local write
  assign wp     = mem[7][7];
  assign ser_ok = wr_evt & ((addr == 6'd7) | ~wp);
  assign clash  = wr_evt & loc_we;
  assign loc_ok = loc_we & ~wr_evt & ((loc_addr == 6'd7) | ~wp);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 64; i++)
        mem[i] <= 8'd0;
    end else if (ser_ok) begin
      mem[addr] <= shifted;
    end else if (loc_ok) begin
      mem[loc_addr] <= loc_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      io_out        <= 1'b0;
      io_oe         <= 1'b0;
      wr_strobe     <= 1'b0;
      rd_strobe     <= 1'b0;
      loc_collision <= 1'b0;
      loc_rdata     <= 8'd0;
      evt_addr      <= 6'd0;
    end else begin
      io_out        <= io_out_n;
      io_oe         <= io_oe_n;
      wr_strobe     <= wr_evt;
      rd_strobe     <= rd_evt;
      loc_collision <= clash;
      loc_rdata     <= mem[loc_addr];
      if (wr_evt || rd_evt)
        evt_addr <= addr_n;
    end
  end

endmodule

// File: tb/tb_ds1302_slave.sv
// tb_ds1302_slave: drives the 3-wire host side and the local port,
// checking every cycle against a transaction-level register-file model.
module tb_ds1302_slave;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ce_in, sclk_in, io_in;
  logic       io_out, io_oe;
  logic [5:0] loc_addr;
  logic [7:0] loc_wdata;
  logic       loc_we;
  logic [7:0] loc_rdata;
  logic       wr_strobe, rd_strobe;
  logic [5:0] evt_addr;
  logic       loc_collision;

  ds1302_slave dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ce_in         (ce_in),
    .sclk_in       (sclk_in),
    .io_in         (io_in),
    .io_out        (io_out),
    .io_oe         (io_oe),
    .loc_addr      (loc_addr),
    .loc_wdata     (loc_wdata),
    .loc_we        (loc_we),
    .loc_rdata     (loc_rdata),
    .wr_strobe     (wr_strobe),
    .rd_strobe     (rd_strobe),
    .evt_addr      (evt_addr),
    .loc_collision (loc_collision)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] model_mem [64];
  logic       exp_oe, exp_out, exp_wr, exp_rd, exp_col;
  logic [5:0] exp_evt;
  logic [7:0] exp_rdata;
  bit         chk_en = 1'b0;

  int         n_wr, n_rd, n_col, n_oe;
  logic [7:0] cap;
  int         oe_falls, oe_off;

  task automatic check(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    n_wr  += int'(wr_strobe);
    n_rd  += int'(rd_strobe);
    n_col += int'(loc_collision);
    n_oe  += int'(io_oe);
    if (chk_en) begin
      check("io_oe", {7'd0, io_oe}, {7'd0, exp_oe});
      if (exp_oe)
        check("io_out", {7'd0, io_out}, {7'd0, exp_out});
      check("wr_strobe", {7'd0, wr_strobe}, {7'd0, exp_wr});
      check("rd_strobe", {7'd0, rd_strobe}, {7'd0, exp_rd});
      check("loc_collision", {7'd0, loc_collision}, {7'd0, exp_col});
      check("evt_addr", {2'd0, evt_addr}, {2'd0, exp_evt});
      check("loc_rdata", loc_rdata, exp_rdata);
    end
  end

  // one clk: DUT registers the read port from the file as it was before the edge
  task automatic cyc();
    @(posedge clk);
    #1;
    exp_wr    = 1'b0;
    exp_rd    = 1'b0;
    exp_col   = 1'b0;
    exp_rdata = model_mem[loc_addr];
  endtask

  task automatic clear_counts();
    n_wr  = 0;
    n_rd  = 0;
    n_col = 0;
    n_oe  = 0;
  endtask

  task automatic do_reset();
    chk_en  = 1'b0;
    reset_n = 1'b0;
    repeat (3) cyc();
    check("rst io_out", {7'd0, io_out}, 8'd0);
    check("rst io_oe", {7'd0, io_oe}, 8'd0);
    check("rst loc_rdata", loc_rdata, 8'd0);
    check("rst wr_strobe", {7'd0, wr_strobe}, 8'd0);
    check("rst rd_strobe", {7'd0, rd_strobe}, 8'd0);
    check("rst evt_addr", {2'd0, evt_addr}, 8'd0);
    check("rst collision", {7'd0, loc_collision}, 8'd0);
    for (int i = 0; i < 64; i++)
      model_mem[i] = 8'd0;
    exp_oe    = 1'b0;
    exp_out   = 1'b0;
    exp_evt   = 6'd0;
    exp_rdata = 8'd0;
    reset_n   = 1'b1;
    cyc();
    chk_en = 1'b1;
  endtask

  task automatic loc_write(input logic [5:0] a, input logic [7:0] d);
    loc_addr  = a;
    loc_wdata = d;
    loc_we    = 1'b1;
    cyc();
    if (a == 6'd7 || !model_mem[7][7])
      model_mem[a] = d;
    loc_we = 1'b0;
    cyc();
  endtask

  task automatic peek(input string nm, input logic [5:0] a,
                      input logic [7:0] e);
    loc_addr = a;
    cyc();
    cyc();
    check(nm, loc_rdata, e);
  endtask

  // nclk full SCLK periods (16 = complete transfer), then CE drops
  task automatic xfer(input logic [7:0] cmd, input logic [7:0] data,
                      input int nclk, input bit col,
                      input logic [7:0] cdat);
    logic [15:0] bits;
    logic [7:0]  snap;
    logic [5:0]  a;
    bit          ok, rd;
    int          r;
    bits     = {data, cmd};
    ok       = cmd[7];
    rd       = cmd[0];
    a        = cmd[6:1];
    snap     = 8'd0;
    cap      = 8'd0;
    oe_falls = 0;
    oe_off   = -1;
    ce_in    = 1'b1;
    repeat (5) cyc();
    for (int i = 0; i < nclk; i++) begin
      io_in = bits[i];
      repeat (2) cyc();
      sclk_in = 1'b1;
      for (int k = 1; k <= 5; k++) begin
        cyc();
        if (k == 2 && col && i == 15 && ok && !rd) begin
          loc_addr  = a;
          loc_wdata = cdat;
          loc_we    = 1'b1;
        end
        if (k == 3 && ok && rd && i == 7) begin
          exp_rd  = 1'b1;
          exp_evt = a;
          snap    = model_mem[a];
        end
        if (k == 3 && ok && !rd && i == 15) begin
          exp_wr  = 1'b1;
          exp_evt = a;
          if (a == 6'd7 || !model_mem[7][7])
            model_mem[a] = data;
          if (col) begin
            exp_col = 1'b1;
            loc_we  = 1'b0;
          end
        end
      end
      sclk_in = 1'b0;
      for (int k = 1; k <= 5; k++) begin
        cyc();
        r = i - 7;
        if (k == 3 && ok && rd && r >= 0) begin
          if (r < 8) begin
            exp_oe  = 1'b1;
            exp_out = snap[r];
          end else begin
            exp_oe = 1'b0;
          end
        end
        if (k == 5 && ok && rd && r >= 0 && r < 8 && io_oe) begin
          oe_falls++;
          cap[r] = io_out;
        end
      end
    end
    ce_in = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      if (k == 3)
        exp_oe = 1'b0;
      if (oe_off < 0 && !io_oe)
        oe_off = k;
    end
    repeat (3) cyc();
  endtask

  logic [7:0] rc, rdat;
  int         rn;
  bit         rcol;

  initial begin
    reset_n   = 1'b0;
    ce_in     = 1'b0;
    sclk_in   = 1'b0;
    io_in     = 1'b0;
    loc_addr  = 6'd0;
    loc_wdata = 8'd0;
    loc_we    = 1'b0;
    for (int i = 0; i < 64; i++)
      model_mem[i] = 8'd0;
    exp_oe    = 1'b0;
    exp_out   = 1'b0;
    exp_wr    = 1'b0;
    exp_rd    = 1'b0;
    exp_col   = 1'b0;
    exp_evt   = 6'd0;
    exp_rdata = 8'd0;
    clear_counts();
    do_reset();

    clear_counts();
    xfer(8'h80, 8'h59, 16, 1'b0, 8'h00);
    check("wr count", 8'(n_wr), 8'd1);
    check("wr evt_addr", {2'd0, evt_addr}, 8'h00);
    peek("wr clock0", 6'h00, 8'h59);

    loc_write(6'h25, 8'hA6);
    clear_counts();
    xfer(8'hCB, 8'h00, 16, 1'b0, 8'h00);
    check("rd byte", cap, 8'hA6);
    check("rd oe falls", 8'(oe_falls), 8'd8);
    check("rd count", 8'(n_rd), 8'd1);
    check("rd evt_addr", {2'd0, evt_addr}, 8'h25);

    xfer(8'h8E, 8'h80, 16, 1'b0, 8'h00);
    clear_counts();
    xfer(8'h84, 8'h12, 16, 1'b0, 8'h00);
    check("wp strobe", 8'(n_wr), 8'd1);
    peek("wp blocked", 6'h02, 8'h00);
    xfer(8'h8E, 8'h00, 16, 1'b0, 8'h00);
    xfer(8'h84, 8'h12, 16, 1'b0, 8'h00);
    peek("wp cleared", 6'h02, 8'h12);

    clear_counts();
    xfer(8'hC6, 8'h77, 12, 1'b0, 8'h00);
    check("abort wr count", 8'(n_wr), 8'd0);
    peek("abort ram3", 6'h23, 8'h00);
    xfer(8'hCB, 8'h00, 10, 1'b0, 8'h00);
    check("abort rd bits", 8'(oe_falls), 8'd3);
    check("abort oe off", {7'd0, oe_off >= 1 && oe_off <= 4}, 8'd1);

    clear_counts();
    xfer(8'h02, 8'h5A, 16, 1'b0, 8'h00);
    check("inv wr", 8'(n_wr), 8'd0);
    check("inv rd", 8'(n_rd), 8'd0);
    check("inv oe", 8'(n_oe), 8'd0);

    clear_counts();
    xfer(8'h80, 8'h22, 16, 1'b1, 8'h11);
    check("col count", 8'(n_col), 8'd1);
    peek("col clock0", 6'h00, 8'h22);

    for (int t = 0; t < 40; t++) begin
      rc    = 8'($urandom);
      rc[7] = ($urandom_range(0, 9) != 0);
      rdat  = 8'($urandom);
      rn    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 16;
      rcol  = rc[7] && !rc[0] && rn == 16 && $urandom_range(0, 3) == 0;
      xfer(rc, rdat, rn, rcol, 8'($urandom));
      if ($urandom_range(0, 2) == 0)
        loc_write(6'($urandom), 8'($urandom));
      if ($urandom_range(0, 4) == 0)
        loc_write(6'd7, 8'h00);
      loc_addr = 6'($urandom);
      cyc();
    end

    loc_addr = 6'h25;
    do_reset();
    peek("reset clears", 6'h25, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
